// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: Moore main FSM plus the R-type ALU decoder.
// Selects and enables are registered alongside the state; only alu_control in
// EXECUTE and illegal_op in DECODE look at the IR fields combinationally.
module mips_multicycle_controller #(
   parameter int FUNCT_W   = 6,
   parameter int ALU_CTL_W = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [FUNCT_W-1:0]   opcode,
   input  logic [FUNCT_W-1:0]   funct,
   output logic                 mem_to_reg,
   output logic                 reg_dest,
   output logic                 i_or_d,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           pc_src,
   output logic [ALU_CTL_W-1:0] alu_control,
   output logic                 ir_write,
   output logic                 mem_write,
   output logic                 pc_write,
   output logic                 branch,
   output logic                 reg_write,
   output logic                 illegal_op,
   output logic [3:0]           state_dbg
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   // All state-derived datapath controls, registered as one word.
   typedef struct packed {
      logic                 mem_to_reg;
      logic                 reg_dest;
      logic                 i_or_d;
      logic                 alu_src_a;
      logic [1:0]           alu_src_b;
      logic [1:0]           pc_src;
      logic [ALU_CTL_W-1:0] alu_control;
      logic                 ir_write;
      logic                 mem_write;
      logic                 pc_write;
      logic                 branch;
      logic                 reg_write;
   } ctl_t;

   localparam logic [FUNCT_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [FUNCT_W-1:0] OP_LW    = 6'b100011;
   localparam logic [FUNCT_W-1:0] OP_SW    = 6'b101011;
   localparam logic [FUNCT_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [FUNCT_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [FUNCT_W-1:0] OP_J     = 6'b000010;

   localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
   localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
   localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
   localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
   localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

   localparam logic [ALU_CTL_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_CTL_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_CTL_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_CTL_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_CTL_W-1:0] ALU_SLT = 3'b111;

   state_t state;
   state_t state_nxt;
   ctl_t   ctl_q;

   // Unknown functs fall back to add so the instruction still retires.
   function automatic logic [ALU_CTL_W-1:0] alu_decode(input logic [FUNCT_W-1:0] fn);
      logic [ALU_CTL_W-1:0] a;
      case (fn)
         FN_ADD:  a = ALU_ADD;
         FN_SUB:  a = ALU_SUB;
         FN_AND:  a = ALU_AND;
         FN_OR:   a = ALU_OR;
         FN_SLT:  a = ALU_SLT;
         default: a = ALU_ADD;
      endcase
      return a;
   endfunction

   function automatic logic op_supported(input logic [FUNCT_W-1:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

   function automatic state_t next_of(input state_t s, input logic [FUNCT_W-1:0] op);
      state_t n;
      n = S_FETCH;
      case (s)
         S_FETCH:   n = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: n = S_MEMADR;
               OP_RTYPE:     n = S_EXECUTE;
               OP_BEQ:       n = S_BRANCH;
               OP_ADDI:      n = S_ADDIEX;
               OP_J:         n = S_JUMP;
               default:      n = S_FETCH;
            endcase
         end
         S_MEMADR:  n = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   n = S_MEMWB;
         S_EXECUTE: n = S_ALUWB;
         S_ADDIEX:  n = S_ADDIWB;
         default:   n = S_FETCH;
      endcase
      return n;
   endfunction

   // Controls for a given state; anything not named stays 0, including the
   // unused encodings.
   function automatic ctl_t ctl_for(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.ir_write    = 1'b1;
            c.alu_src_b   = 2'b01;
            c.alu_control = ALU_ADD;
            c.pc_write    = 1'b1;
         end
         S_DECODE: begin
            c.alu_src_b   = 2'b11;
            c.alu_control = ALU_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            c.alu_src_a   = 1'b1;
            c.alu_src_b   = 2'b10;
            c.alu_control = ALU_ADD;
         end
         S_MEMRD: c.i_or_d = 1'b1;
         S_MEMWB: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            c.i_or_d    = 1'b1;
            c.mem_write = 1'b1;
         end
         S_EXECUTE: begin
            c.alu_src_a   = 1'b1;
            c.alu_control = ALU_ADD;
         end
         S_ALUWB: begin
            c.reg_dest  = 1'b1;
            c.reg_write = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a   = 1'b1;
            c.alu_control = ALU_SUB;
            c.pc_src      = 2'b01;
            c.branch      = 1'b1;
         end
         S_ADDIWB: c.reg_write = 1'b1;
         S_JUMP: begin
            c.pc_src   = 2'b10;
            c.pc_write = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   assign state_nxt = next_of(state, opcode);

   // State and its controls advance together so outputs come straight from flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FETCH;
         ctl_q <= ctl_for(S_FETCH);
      end else begin
         state <= state_nxt;
         ctl_q <= ctl_for(state_nxt);
      end
   end

   assign mem_to_reg  = ctl_q.mem_to_reg;
   assign reg_dest    = ctl_q.reg_dest;
   assign i_or_d      = ctl_q.i_or_d;
   assign alu_src_a   = ctl_q.alu_src_a;
   assign alu_src_b   = ctl_q.alu_src_b;
   assign pc_src      = ctl_q.pc_src;
   assign alu_control = (state == S_EXECUTE) ? alu_decode(funct) : ctl_q.alu_control;

   // Enables are gated by rst_n so nothing can fire while reset is held,
   // even though the flops sit at their FETCH values.
   assign ir_write   = ctl_q.ir_write  & rst_n;
   assign mem_write  = ctl_q.mem_write & rst_n;
   assign pc_write   = ctl_q.pc_write  & rst_n;
   assign branch     = ctl_q.branch    & rst_n;
   assign reg_write  = ctl_q.reg_write & rst_n;
   assign illegal_op = rst_n & (state == S_DECODE) & ~op_supported(opcode);

   assign state_dbg = state;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for the multicycle MIPS controller: directed instruction cases, a
// mid-instruction reset, then random instructions checked against a
// per-instruction reference of state sequence and control values.
module tb_mips_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode, funct;
   logic       mem_to_reg, reg_dest, i_or_d, alu_src_a;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_control;
   logic       ir_write, mem_write, pc_write, branch, reg_write, illegal_op;
   logic [3:0] state_dbg;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mips_multicycle_controller #(.FUNCT_W(6), .ALU_CTL_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
      .mem_to_reg(mem_to_reg), .reg_dest(reg_dest), .i_or_d(i_or_d),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .alu_control(alu_control), .ir_write(ir_write), .mem_write(mem_write),
      .pc_write(pc_write), .branch(branch), .reg_write(reg_write),
      .illegal_op(illegal_op), .state_dbg(state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic legal_op(input logic [5:0] op);
      return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] fn);
      case (fn)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Control word packed as {m2r,rd,iod,asa,asb,pcs,alu,irw,mw,pw,br,rw,ill}.
   function automatic logic [16:0] exp_vec(input int st, input logic [5:0] op, input logic [5:0] fn);
      logic m2r, rd, iod, asa, irw, mw, pw, br, rw, ill;
      logic [1:0] asb, pcs;
      logic [2:0] alu;
      {m2r, rd, iod, asa, irw, mw, pw, br, rw, ill} = '0;
      asb = 2'b00; pcs = 2'b00; alu = 3'b000;
      case (st)
         0:  begin irw = 1; asb = 2'b01; alu = 3'b010; pw = 1; end
         1:  begin asb = 2'b11; alu = 3'b010; ill = !legal_op(op); end
         2:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
         3:  iod = 1;
         4:  begin m2r = 1; rw = 1; end
         5:  begin iod = 1; mw = 1; end
         6:  begin asa = 1; alu = alu_of(fn); end
         7:  begin rd = 1; rw = 1; end
         8:  begin asa = 1; alu = 3'b110; pcs = 2'b01; br = 1; end
         9:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
         10: rw = 1;
         11: begin pcs = 2'b10; pw = 1; end
         default: ;
      endcase
      return {m2r, rd, iod, asa, asb, pcs, alu, irw, mw, pw, br, rw, ill};
   endfunction

   function automatic logic [16:0] obs_vec();
      return {mem_to_reg, reg_dest, i_or_d, alu_src_a, alu_src_b, pc_src, alu_control,
              ir_write, mem_write, pc_write, branch, reg_write, illegal_op};
   endfunction

   task automatic check_cycle(input string tag, input int st, input logic [5:0] op, input logic [5:0] fn);
      check({tag, "_state"}, 32'(state_dbg), 32'(st));
      check({tag, "_ctl"}, 32'(obs_vec()), 32'(exp_vec(st, op, fn)));
      check({tag, "_mw_rw_excl"}, 32'(mem_write & reg_write), 32'd0);
      check({tag, "_pw_br_excl"}, 32'(pc_write & branch), 32'd0);
   endtask

   // Called just after a falling edge while in FETCH; returns the same way.
   task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn);
      int seq[$];
      seq = {0, 1};
      case (op)
         6'b100011: seq = {0, 1, 2, 3, 4};
         6'b101011: seq = {0, 1, 2, 5};
         6'b000000: seq = {0, 1, 6, 7};
         6'b000100: seq = {0, 1, 8};
         6'b001000: seq = {0, 1, 9, 10};
         6'b000010: seq = {0, 1, 11};
         default:   seq = {0, 1};
      endcase
      check_cycle({tag, "_c0"}, seq[0], op, fn);
      @(posedge clk); #1;
      opcode = op;
      funct  = fn;
      for (int k = 1; k < seq.size(); k++) begin
         @(negedge clk); #1;
         check_cycle($sformatf("%s_c%0d", tag, k), seq[k], op, fn);
      end
      @(negedge clk); #1;
   endtask

   initial begin
      logic [5:0] op, fn;
      rst_n = 1'b0; opcode = 6'b000000; funct = 6'b000000;

      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("rst_state", 32'(state_dbg), 32'd0);
      check("rst_ctl", 32'(obs_vec()), 32'(exp_vec(0, 6'd0, 6'd0) & ~17'h3F));
      rst_n = 1'b1;
      #1;
      check("rel_ir_write", 32'(ir_write), 32'd1);
      check("rel_pc_write", 32'(pc_write), 32'd1);

      run_instr("lw",     6'b100011, 6'b000000);
      run_instr("sw",     6'b101011, 6'b000000);
      run_instr("r_sub",  6'b000000, 6'b100010);
      run_instr("r_slt",  6'b000000, 6'b101010);
      run_instr("r_unk",  6'b000000, 6'b000000);
      run_instr("r_and",  6'b000000, 6'b100100);
      run_instr("r_or",   6'b000000, 6'b100101);
      run_instr("beq",    6'b000100, 6'b000000);
      run_instr("j",      6'b000010, 6'b000000);
      run_instr("ill",    6'b111111, 6'b000000);
      run_instr("addi",   6'b001000, 6'b000000);

      // Reset while in MEMRD of a load.
      check_cycle("ab_c0", 0, 6'b100011, 6'd0);
      @(posedge clk); #1;
      opcode = 6'b100011;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk); #1;
         check_cycle($sformatf("ab_c%0d", k), k, 6'b100011, 6'd0);
      end
      rst_n = 1'b0;
      #1;
      check("ab_state_now", 32'(state_dbg), 32'd0);
      check("ab_enables", 32'(obs_vec() & 17'h3F), 32'd0);
      @(posedge clk); #1;
      check("ab_held_state", 32'(state_dbg), 32'd0);
      check("ab_no_reg_write", 32'(reg_write), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 6))
            0: op = 6'b100011;
            1: op = 6'b101011;
            2: op = 6'b000000;
            3: op = 6'b000100;
            4: op = 6'b001000;
            5: op = 6'b000010;
            default: begin
               op = 6'($urandom);
               while (legal_op(op)) op = 6'($urandom);
            end
         endcase
         case ($urandom_range(0, 5))
            0: fn = 6'b100000;
            1: fn = 6'b100010;
            2: fn = 6'b100100;
            3: fn = 6'b100101;
            4: fn = 6'b101010;
            default: fn = 6'($urandom);
         endcase
         run_instr($sformatf("rnd%0d", n), op, fn);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
